// File: rtl/alu_inst_loader.sv
// alu_inst_loader: instruction issue stage in front of the ALU.
// Buffers (opcode, A, B) instructions in a FIFO, writes each one into the
// ALU instruction register file as three byte writes (addr 0, 1, 2), waits
// RESULT_LATENCY cycles, captures result and flags, and offers them on a
// valid/ready response port.
// Optional feature macro: ALU_LOADER_OPCODE_CHECK_EN. When defined, opcodes
// above MAX_OPCODE are rejected at pop time without touching the ALU.
module alu_inst_loader #(
    parameter int OPERAND_WIDTH    = 8,
    parameter int INST_ADDR_LENGTH = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int RESULT_LATENCY   = 1,
    parameter logic [OPERAND_WIDTH-1:0] MAX_OPCODE = OPERAND_WIDTH'(8'h1F)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPERAND_WIDTH-1:0]      in_opcode,
    input  logic [OPERAND_WIDTH-1:0]      in_a,
    input  logic [OPERAND_WIDTH-1:0]      in_b,
    output logic                          alu_write_en,
    output logic [INST_ADDR_LENGTH-1:0]   alu_write_address,
    output logic [OPERAND_WIDTH-1:0]      alu_inst,
    input  logic [OPERAND_WIDTH-1:0]      alu_result,
    input  logic                          alu_error,
    input  logic                          alu_overflow,
    input  logic                          alu_zero,
    input  logic                          alu_carry,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPERAND_WIDTH-1:0]      out_result,
    output logic [3:0]                    out_flags,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

`ifdef ALU_LOADER_OPCODE_CHECK_EN
    localparam logic OPCODE_CHECK = 1'b1;
`else
    localparam logic OPCODE_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_OP = 3'd1,
        S_WR_A  = 3'd2,
        S_WR_B  = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // FIFO storage (data only; occupancy lives in the pointers/count)
    logic [OPERAND_WIDTH-1:0] r_mem_op [FIFO_DEPTH];
    logic [OPERAND_WIDTH-1:0] r_mem_a  [FIFO_DEPTH];
    logic [OPERAND_WIDTH-1:0] r_mem_b  [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    // Instruction being issued and captured response
    logic [OPERAND_WIDTH-1:0] r_cur_op;
    logic [OPERAND_WIDTH-1:0] r_cur_a;
    logic [OPERAND_WIDTH-1:0] r_cur_b;
    logic [LAT_W-1:0]         r_lat_cnt;
    logic [OPERAND_WIDTH-1:0] r_result;
    logic [3:0]               r_flags;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_op_illegal;
    logic [OPERAND_WIDTH-1:0] w_head_op;

    // Full is judged on the registered count, so a same-cycle pop never
    // reopens the input while full.
    assign in_ready     = ~rst & (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push       = in_valid & in_ready;
    assign w_pop        = (r_state == S_IDLE) & (r_count != {CNT_W{1'b0}});
    assign w_head_op    = r_mem_op[r_rd_ptr];
    assign w_op_illegal = OPCODE_CHECK & (w_head_op > MAX_OPCODE);

    assign fifo_count   = r_count;
    assign out_valid    = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign out_result   = r_result;
    assign out_flags    = r_flags;

    // FIFO data write on accepted push (no reset needed on payload)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= in_opcode;
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and ALU write-port decode
    always_comb begin
        w_state_nxt       = r_state;
        alu_write_en      = 1'b0;
        alu_write_address = {INST_ADDR_LENGTH{1'b0}};
        alu_inst          = {OPERAND_WIDTH{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_op_illegal ? S_RESP : S_WR_OP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_OP: begin
                alu_write_en      = 1'b1;
                alu_write_address = INST_ADDR_LENGTH'(0);
                alu_inst          = r_cur_op;
                w_state_nxt       = S_WR_A;
            end
            S_WR_A: begin
                alu_write_en      = 1'b1;
                alu_write_address = INST_ADDR_LENGTH'(1);
                alu_inst          = r_cur_a;
                w_state_nxt       = S_WR_B;
            end
            S_WR_B: begin
                alu_write_en      = 1'b1;
                alu_write_address = INST_ADDR_LENGTH'(2);
                alu_inst          = r_cur_b;
                w_state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == {LAT_W{1'b0}}) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue datapath: latch popped instruction, run latency counter, capture response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_op  <= {OPERAND_WIDTH{1'b0}};
            r_cur_a   <= {OPERAND_WIDTH{1'b0}};
            r_cur_b   <= {OPERAND_WIDTH{1'b0}};
            r_lat_cnt <= {LAT_W{1'b0}};
            r_result  <= {OPERAND_WIDTH{1'b0}};
            r_flags   <= 4'b0000;
        end else begin
            if (w_pop) begin
                r_cur_op <= w_head_op;
                r_cur_a  <= r_mem_a[r_rd_ptr];
                r_cur_b  <= r_mem_b[r_rd_ptr];
                if (w_op_illegal) begin
                    // Rejected opcode: answer with the error flag only
                    r_result <= {OPERAND_WIDTH{1'b0}};
                    r_flags  <= 4'b1000;
                end
            end
            if (r_state == S_WR_B) begin
                r_lat_cnt <= LAT_W'(RESULT_LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_lat_cnt != {LAT_W{1'b0}})) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end else begin
                r_lat_cnt <= r_lat_cnt;
            end
            if ((r_state == S_WAIT) && (r_lat_cnt == {LAT_W{1'b0}})) begin
                r_result <= alu_result;
                r_flags  <= {alu_error, alu_overflow, alu_zero, alu_carry};
            end
        end
    end

endmodule
